nlc_output_decimator: RTL and testbench
=======================================

NLC_OUTPUT_DECIMATOR -- requirements
Module: nlc_output_decimator

Interface
REQ-001 SHALL have these ports, clock and reset first: clk  input  1  system clock; single clock domain, all logic rising-edge.
REQ-002 SHALL have: GlobalReset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: x_lin  input  21  sfix21 linearised sample from the NLC engine.
REQ-004 SHALL have: srdyi  input  1  x_lin valid strobe; driven by the NLC engine's srdyo.
REQ-005 SHALL have: en  input  1  decimator enable; low aborts the current frame and holds the block idle.
REQ-006 SHALL have: decim_log2  input  4  ufix4 frame length exponent k; frame = 2^k samples; values >8 are treated as 8.
REQ-007 SHALL have: x_dec  output  21  sfix21 rounded frame average.
REQ-008 SHALL have: srdyo  output  1  x_dec valid strobe, one cycle wide.
REQ-009 SHALL have: frame_cnt  output  16  ufix16 count of frames emitted since reset; wraps 65535->0.

Function
REQ-010 SHALL accept a sample only in a cycle where srdyi=1 and en=1; srdyi may be asserted in consecutive cycles (full rate) or sparsely.
REQ-011 SHALL latch k = min(decim_log2, 8) on the first accepted sample of each frame (sample count 0); changes mid-frame take effect from the next frame only.
REQ-012 SHALL accumulate accepted samples into a signed accumulator of at least 30 bits; no intermediate wrap is permitted.
REQ-013 SHALL keep a sample counter 0..2^k-1 that increments on each accepted sample and returns to 0 after the last sample of a frame.
REQ-014 SHALL compute the result on the last sample of a frame as (sum + 2^(k-1)) >>> k (arithmetic shift, round half toward +inf); for k=0 the result is the sample unchanged.
REQ-015 SHALL apply no saturation, because the result is provably within the sfix21 range; the implementation SHALL still truncate to 21 bits.
REQ-016 SHALL assert srdyo for exactly one cycle, in the cycle after the srdyi cycle that carried the frame's last sample; latency is 1 clock.
REQ-017 SHALL update x_dec only when srdyo asserts, and SHALL hold x_dec between outputs.
REQ-018 SHALL increment frame_cnt in the same cycle that srdyo asserts.
REQ-019 SHALL, when a frame's last sample and the next frame's first sample arrive on consecutive cycles, seed the accumulator with the new sample (not add it to the old sum); no bubble is permitted.
REQ-020 SHALL, while en=0, clear the accumulator and sample counter, ignore srdyi and keep srdyo=0; x_dec and frame_cnt hold their values.
REQ-021 SHALL, when en falls in the same cycle as a frame's last sample, discard that sample and emit no output.
REQ-022 SHALL start a fresh frame on the first accepted sample after en rises, latching k again per REQ-011.
REQ-023 SHALL have a two-state control: IDLE (en=0 or after reset) and ACCUM. IDLE->ACCUM when en=1. ACCUM->IDLE when en=0. The frame boundary is tracked by the counter, not by a state.

Reset
REQ-024 SHALL, while GlobalReset=1 at a rising edge, set x_dec=0, srdyo=0, frame_cnt=0, accumulator=0, sample counter=0 and state=IDLE; reset has priority over every other input.
REQ-025 SHALL, on reset asserted mid-frame, discard the partial frame; the first accepted sample after release starts a new frame.
REQ-026 SHALL NOT emit srdyo in the cycle immediately after reset release, even if srdyi=1 during reset.

Verification
REQ-027 SHALL cover passthrough: k=0, en=1, x_lin=-5, 100, 1048575 on consecutive srdyi cycles -> x_dec=-5, 100, 1048575, each 1 cycle late; srdyo high 3 consecutive cycles; frame_cnt=3.
REQ-028 SHALL cover rounding: k=2, samples 1,2,2,2 (sum 7) -> x_dec=2. Samples -1,-2,-2,-2 (sum -7) -> x_dec=-2. Samples -1,-1,-1,-3 (sum -6) -> x_dec=-1 (half rounds up).
REQ-029 SHALL cover extremes: k=8, 256 samples of -1048576 -> x_dec=-1048576. Then 256 samples of 1048575 -> x_dec=1048575, with no overflow.
REQ-030 SHALL cover mid-frame config change: k=2 is latched; decim_log2 changes to 1 after sample 2 -> the current frame still averages 4 samples, and the next frame averages 2.
REQ-031 SHALL cover abort: k=3, en drops after 5 samples, then rises -> no srdyo for the partial frame; the next 8 samples of value 10 -> x_dec=10, frame_cnt incremented by 1.
REQ-032 SHALL cover reset mid-frame: k=2, GlobalReset pulsed after 3 samples -> all outputs 0; the next 4 samples of 4 -> x_dec=4, frame_cnt=1.

Source files
------------

// File: rtl/nlc_output_decimator.sv
// rtl/nlc_output_decimator.sv - frame-averaging decimator for NLC engine output
// Averages 2^k accepted samples with round-half-up, one-cycle output latency.
module nlc_output_decimator (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic [20:0] x_lin,
  input  logic        srdyi,
  input  logic        en,
  input  logic [3:0]  decim_log2,
  output logic [20:0] x_dec,
  output logic        srdyo,
  output logic [15:0] frame_cnt
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [29:0] r_acc;
  logic [7:0]         r_cnt;
  logic [3:0]         r_k;
  logic [20:0]        r_x_dec;
  logic               r_srdyo;
  logic [15:0]        r_frame_cnt;

  logic               w_accept;
  logic               w_first;
  logic [3:0]         w_k;
  logic [8:0]         w_lim;
  logic               w_last;
  logic signed [29:0] w_x_ext;
  logic signed [29:0] w_sum;
  logic signed [30:0] w_half;
  logic signed [30:0] w_rnd;
  logic [20:0]        w_res;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_state_nxt = S_ACCUM;
      S_ACCUM: if (!en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // k is taken from the port only on the first sample of a frame
  assign w_accept = en & srdyi;
  assign w_first  = (r_cnt == 8'd0);
  assign w_k      = w_first ? ((decim_log2 > 4'd8) ? 4'd8 : decim_log2) : r_k;
  assign w_lim    = (9'd1 << w_k) - 9'd1;
  assign w_last   = ({1'b0, r_cnt} == w_lim);

  // The first sample seeds the sum so back-to-back frames need no bubble
  assign w_x_ext  = $signed({{9{x_lin[20]}}, x_lin});
  assign w_sum    = (w_first ? 30'sd0 : r_acc) + w_x_ext;
  assign w_half   = (w_k == 4'd0) ? 31'sd0 : (31'sd1 <<< (w_k - 4'd1));
  assign w_rnd    = $signed({w_sum[29], w_sum}) + w_half;
  assign w_res    = 21'(w_rnd >>> w_k);

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_x_dec     <= '0;
      r_srdyo     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_srdyo <= 1'b0;
      if (!en) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_k <= w_k;
        if (w_last) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_x_dec     <= w_res;
          r_srdyo     <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign x_dec     = r_x_dec;
  assign srdyo     = r_srdyo;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_nlc_output_decimator.sv
// tb/tb_nlc_output_decimator.sv - self-checking bench for nlc_output_decimator
// Frame-queue reference model checked every cycle, plus directed literal checks.
module tb_nlc_output_decimator;

  logic        clk = 1'b0;
  logic        GlobalReset = 1'b1;
  logic [20:0] x_lin = '0;
  logic        srdyi = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  decim_log2 = '0;
  logic [20:0] x_dec;
  logic        srdyo;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  int q[$];
  int mk = 0;
  int exp_xdec = 0;
  int exp_srdyo = 0;
  int exp_fc = 0;

  nlc_output_decimator dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .x_lin      (x_lin),
    .srdyi      (srdyi),
    .en         (en),
    .decim_log2 (decim_log2),
    .x_dec      (x_dec),
    .srdyo      (srdyo),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Average of a full frame, rounded half toward +inf
  task automatic model(input int rst, input int e, input int s, input int x, input int dl);
    longint sum;
    int n;
    if (rst != 0) begin
      q.delete();
      exp_xdec = 0; exp_srdyo = 0; exp_fc = 0;
      return;
    end
    exp_srdyo = 0;
    if (e == 0) begin
      q.delete();
      return;
    end
    if (s == 0) return;
    if (q.size() == 0) mk = (dl > 8) ? 8 : dl;
    q.push_back(x);
    n = 1 << mk;
    if (q.size() == n) begin
      sum = 0;
      foreach (q[i]) sum += q[i];
      exp_xdec = int'(floor_div(2 * sum + n, 2 * n));
      exp_srdyo = 1;
      exp_fc = (exp_fc + 1) % 65536;
      q.delete();
    end
  endtask

  task automatic step(input int rst, input int e, input int s, input int x, input int dl);
    GlobalReset = rst[0];
    en          = e[0];
    srdyi       = s[0];
    x_lin       = x[20:0];
    decim_log2  = dl[3:0];
    model(rst, e, s, x, dl);
    @(posedge clk);
    #1;
    chk("srdyo", int'(srdyo), exp_srdyo);
    chk("x_dec", int'($signed(x_dec)), exp_xdec);
    chk("frame_cnt", int'(frame_cnt), exp_fc);
  endtask

  task automatic frame(input int k, input int v, input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, v, k);
  endtask

  initial begin
    int fc0;
    int xr;

    // Reset with srdyi high; no output right after release
    step(1, 1, 1, 123, 0);
    step(1, 1, 1, 123, 0);
    chk("rst_xdec", int'($signed(x_dec)), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    step(0, 0, 0, 0, 0);
    chk("rel_srdyo", int'(srdyo), 0);

    // Passthrough k=0
    step(0, 1, 1, -5, 0);
    chk("pt0", int'($signed(x_dec)), -5);
    step(0, 1, 1, 100, 0);
    chk("pt1", int'($signed(x_dec)), 100);
    chk("pt1_srdyo", int'(srdyo), 1);
    step(0, 1, 1, 1048575, 0);
    chk("pt2", int'($signed(x_dec)), 1048575);
    chk("pt_fc", int'(frame_cnt), 3);
    step(0, 1, 0, 0, 0);
    chk("pt_done", int'(srdyo), 0);

    // Rounding k=2
    step(0, 1, 1, 1, 2); step(0, 1, 1, 2, 2); step(0, 1, 1, 2, 2); step(0, 1, 1, 2, 2);
    chk("rnd_p7", int'($signed(x_dec)), 2);
    chk("model_p7", exp_xdec, 2);
    step(0, 1, 1, -1, 2); step(0, 1, 1, -2, 2); step(0, 1, 1, -2, 2); step(0, 1, 1, -2, 2);
    chk("rnd_m7", int'($signed(x_dec)), -2);
    step(0, 1, 1, -1, 2); step(0, 1, 0, 0, 2); step(0, 1, 1, -1, 2);
    step(0, 1, 1, -1, 2); step(0, 1, 1, -3, 2);
    chk("rnd_m6", int'($signed(x_dec)), -1);
    chk("model_m6", exp_xdec, -1);

    // Extremes k=8 (decim_log2 above 8 clamps to 8)
    frame(8, -1048576, 256);
    chk("ext_min", int'($signed(x_dec)), -1048576);
    frame(12, 1048575, 256);
    chk("ext_max", int'($signed(x_dec)), 1048575);
    chk("model_max", exp_xdec, 1048575);

    // Config change mid-frame
    step(0, 1, 1, 10, 2); step(0, 1, 1, 20, 2);
    step(0, 1, 1, 30, 1);
    chk("cfg_mid", int'(srdyo), 0);
    step(0, 1, 1, 40, 1);
    chk("cfg_4", int'($signed(x_dec)), 25);
    step(0, 1, 1, 7, 1); step(0, 1, 1, 8, 1);
    chk("cfg_2", int'($signed(x_dec)), 8);

    // en falls together with the last sample
    step(0, 1, 1, 50, 1);
    step(0, 0, 1, 60, 1);
    chk("enfall", int'(srdyo), 0);
    step(0, 1, 0, 0, 1);

    // Abort after 5 of 8 samples
    fc0 = exp_fc;
    frame(3, 99, 5);
    step(0, 0, 1, 99, 3); step(0, 0, 1, 99, 3);
    chk("abort_srdyo", int'(srdyo), 0);
    frame(3, 10, 8);
    chk("abort_x", int'($signed(x_dec)), 10);
    chk("abort_fc", int'(frame_cnt), fc0 + 1);

    // Reset mid-frame
    frame(2, 77, 3);
    step(1, 1, 1, 77, 2);
    chk("rmid_x", int'($signed(x_dec)), 0);
    chk("rmid_fc", int'(frame_cnt), 0);
    frame(2, 4, 4);
    chk("rmid_x4", int'($signed(x_dec)), 4);
    chk("rmid_fc1", int'(frame_cnt), 1);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      xr = int'($urandom_range(0, 2097151)) - 1048576;
      if ($urandom_range(0, 9) == 0) xr = ($urandom_range(0, 1) != 0) ? 1048575 : -1048576;
      step(($urandom_range(0, 499) == 0) ? 1 : 0,
           ($urandom_range(0, 39) != 0) ? 1 : 0,
           ($urandom_range(0, 2) != 0) ? 1 : 0,
           xr,
           int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
